// File: rtl/mult_pkg.sv
// Shared constants and FSM encoding for the multiplier issue block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_pkg;

  localparam int OP_W        = 32;  // operand width
  localparam int PROD_W      = 64;  // product width
  localparam int TIMEOUT_DEF = 40;  // default WAIT budget in cycles

  // FSM encoding kept as plain constants so legacy tools can consume it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

endpackage

// File: rtl/mult_sign_fix.sv
// Operand magnitude extraction and conditional 64-bit negate of the product.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   a_i, b_i       raw operands
//   signed_i       1 = treat operands as two's complement
//   abs_a_o/abs_b_o magnitudes (0x8000_0000 maps to itself, read as unsigned)
//   neg_o          result sign: set when exactly one signed operand is negative
//   neg_i          registered sign applied to the product
//   prod_i/prod_o  unsigned product in, sign-corrected product out
module mult_sign_fix
  import mult_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  input  logic              signed_i,
  output logic [OP_W-1:0]   abs_a_o,
  output logic [OP_W-1:0]   abs_b_o,
  output logic              neg_o,
  input  logic              neg_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [PROD_W-1:0] prod_o
);

  // ~x+1 on the most negative value wraps back to itself, which is exactly
  // the unsigned magnitude 2^31 the multiplier needs.
  assign abs_a_o = (signed_i && a_i[OP_W-1]) ? (~a_i + 1'b1) : a_i;
  assign abs_b_o = (signed_i && b_i[OP_W-1]) ? (~b_i + 1'b1) : b_i;
  assign neg_o   = signed_i & (a_i[OP_W-1] ^ b_i[OP_W-1]);

  assign prod_o  = neg_i ? (~prod_i + 1'b1) : prod_i;

endmodule

// File: rtl/mult_issue.sv
// Front end for a shift-add multiplier: sign handling, start pulse, timeout.
// Latency: 2 cycles plus multiplier latency from input transfer to out_valid.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready.
//
// Ports:
//   CLK, RST_N                  clock, async active-low reset
//   in_valid/in_ready/in_a/in_b/in_signed   operand handshake
//   mul_multiplicand/mul_multiplier/mul_start  drive to the multiplier
//   mul_done/mul_product        completion from the multiplier
//   out_valid/out_ready/out_product/out_err  result handshake
module mult_issue
  import mult_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_signed,
  output logic [OP_W-1:0]   mul_multiplicand,
  output logic [OP_W-1:0]   mul_multiplier,
  output logic              mul_start,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic              out_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]   mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              err_q, err_d;

  logic [OP_W-1:0]   abs_a, abs_b;
  logic              neg_ab;
  logic [PROD_W-1:0] prod_fix;

  mult_sign_fix u_sign_fix (
    .a_i      (in_a),
    .b_i      (in_b),
    .signed_i (in_signed),
    .abs_a_o  (abs_a),
    .abs_b_o  (abs_b),
    .neg_o    (neg_ab),
    .neg_i    (neg_q),
    .prod_i   (mul_product),
    .prod_o   (prod_fix)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d  = abs_a;
          mplier_d = abs_b;
          neg_d    = neg_ab;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // mul_done is tested first so a completion in the final budget
        // cycle is reported as a good result rather than a timeout.
        if (mul_done) begin
          prod_d  = prod_fix;
          err_d   = 1'b0;
          state_d = ST_HOLD;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Counter would reach TIMEOUT on this edge: WAIT has lasted
          // TIMEOUT cycles with no completion.
          cnt_d   = cnt_q + CW'(1);
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      err_q    <= err_d;
    end
  end

  assign in_ready         = (state_q == ST_IDLE);
  assign mul_start        = (state_q == ST_ISSUE);
  assign out_valid        = (state_q == ST_HOLD);
  assign mul_multiplicand = mcand_q;
  assign mul_multiplier   = mplier_q;
  assign out_product      = prod_q;
  assign out_err          = err_q;

endmodule

// File: tb/tb_mult_issue.sv
module tb_mult_issue;

  localparam int TIMEOUT = 40;

  logic        CLK;
  logic        RST_N;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_signed;
  logic [31:0] mul_multiplicand;
  logic [31:0] mul_multiplier;
  logic        mul_start;
  logic        mul_done;
  logic [63:0] mul_product;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic        out_err;

  int checks;
  int failures;

  mult_issue #(.TIMEOUT(TIMEOUT)) dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .in_signed        (in_signed),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_start        (mul_start),
    .mul_done         (mul_done),
    .mul_product      (mul_product),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product),
    .out_err          (out_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Magnitude of a 32-bit operand as the multiplier should see it.
  function automatic logic [31:0] ref_mag(input logic [31:0] x, input logic s);
    logic [63:0] t;
    if (s && x[31]) t = 64'h1_0000_0000 - {32'h0, x};
    else            t = {32'h0, x};
    return t[31:0];
  endfunction

  // Mathematical product modulo 2^64 of the operands as interpreted.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    longint ea, eb;
    logic [63:0] r;
    ea = s ? longint'($signed(a)) : longint'({32'h0, a});
    eb = s ? longint'($signed(b)) : longint'({32'h0, b});
    r  = ea * eb;
    return r;
  endfunction

  // One full operation. d = cycles from the mul_start cycle to the cycle
  // in which mul_done is driven (1..TIMEOUT); d = 0 means never (timeout).
  // r = cycles out_ready is held low in HOLD.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int d, input int r, input string tag);
    logic [31:0] ea, eb;
    logic [63:0] mp, exp_p;
    logic        exp_e;
    int          limit;
    ea    = ref_mag(a, s);
    eb    = ref_mag(b, s);
    mp    = {32'h0, ea} * {32'h0, eb};
    exp_p = (d == 0) ? 64'h0 : ref_prod(a, b, s);
    exp_e = (d == 0);
    limit = (d == 0) ? TIMEOUT : d;

    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s accept_ready: got %b expected 1", tag, in_ready);
    end
    @(negedge CLK);
    in_valid  = 1'b0;
    in_a      = $urandom;
    in_b      = $urandom;
    in_signed = 1'($urandom);

    checks++;
    if (mul_start !== 1'b1 || mul_multiplicand !== ea || mul_multiplier !== eb ||
        in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s issue: start=%b mcand=%h mplier=%h rdy=%b ov=%b expected 1 %h %h 0 0",
               tag, mul_start, mul_multiplicand, mul_multiplier, in_ready, out_valid, ea, eb);
    end

    for (int i = 1; i <= limit; i++) begin
      @(negedge CLK);
      checks++;
      if (mul_start !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 ||
          mul_multiplicand !== ea || mul_multiplier !== eb) begin
        failures++;
        $display("FAIL %s wait_cycle%0d: start=%b ov=%b rdy=%b mcand=%h mplier=%h expected 0 0 0 %h %h",
                 tag, i, mul_start, out_valid, in_ready, mul_multiplicand, mul_multiplier, ea, eb);
      end
      if (i == d) begin
        mul_done    = 1'b1;
        mul_product = mp;
      end
    end
    @(negedge CLK);
    mul_done    = 1'b0;
    mul_product = {$urandom, $urandom};

    checks++;
    if (out_valid !== 1'b1 || out_product !== exp_p || out_err !== exp_e) begin
      failures++;
      $display("FAIL %s result: ov=%b prod=%h err=%b expected 1 %h %b",
               tag, out_valid, out_product, out_err, exp_p, exp_e);
    end

    for (int i = 0; i < r; i++) begin
      // A stray completion while holding must not disturb the result.
      mul_done = (i == 1);
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b1 || out_product !== exp_p || out_err !== exp_e ||
          in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s hold_cycle%0d: ov=%b prod=%h err=%b rdy=%b expected 1 %h %b 0",
                 tag, i, out_valid, out_product, out_err, in_ready, exp_p, exp_e);
      end
    end
    mul_done  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s no_same_cycle_accept: in_ready=%b expected 0", tag, in_ready);
    end
    @(negedge CLK);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release: ov=%b rdy=%b expected 0 1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    RST_N       = 1'b0;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_signed   = 1'b0;
    mul_done    = 1'b0;
    mul_product = '0;
    out_ready   = 1'b0;
    #1;
    checks++;
    if (mul_start !== 1'b0 || out_valid !== 1'b0 || out_err !== 1'b0 ||
        out_product !== 64'h0 || mul_multiplicand !== 32'h0 || mul_multiplier !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: start=%b ov=%b err=%b prod=%h mcand=%h mplier=%h expected all 0",
               mul_start, out_valid, out_err, out_product, mul_multiplicand, mul_multiplier);
    end
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: rdy=%b ov=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    run_op(32'd3, 32'd5, 1'b0, 3, 0, "unsigned_3x5");
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 2, 0, "signed_m3x5");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1, 0, "signed_minxmin");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4, 0, "unsigned_max");
    run_op(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 5, 1, "signed_7xm2");
  endtask

  task automatic test_timeout();
    run_op($urandom, $urandom, 1'b1, 0, 0, "timeout");
    run_op($urandom, $urandom, 1'b1, TIMEOUT, 0, "done_at_limit");
  endtask

  task automatic test_hold_backpressure();
    run_op(32'hFFFF_FFF0, 32'd9, 1'b1, 6, 10, "hold10");
    run_op($urandom, $urandom, 1'b0, 0, 10, "hold10_timeout");
  endtask

  task automatic test_idle_done_ignored();
    for (int i = 0; i < 4; i++) begin
      mul_done    = 1'b1;
      mul_product = {$urandom, $urandom};
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b0 || mul_start !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL idle_done_%0d: ov=%b start=%b rdy=%b expected 0 0 1",
                 i, out_valid, mul_start, in_ready);
      end
    end
    mul_done = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    in_valid  = 1'b1;
    in_a      = $urandom;
    in_b      = $urandom;
    in_signed = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (5) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || mul_start !== 1'b0 || in_ready !== 1'b1 ||
        mul_multiplicand !== 32'h0 || mul_multiplier !== 32'h0) begin
      failures++;
      $display("FAIL midwait_reset: ov=%b start=%b rdy=%b mcand=%h mplier=%h expected 0 0 1 0 0",
               out_valid, mul_start, in_ready, mul_multiplicand, mul_multiplier);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // The abandoned multiplication finishing late must not surface.
      mul_done    = (i == 0);
      mul_product = {$urandom, $urandom};
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || mul_start !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_%0d: ov=%b rdy=%b start=%b expected 0 1 0",
                 i, out_valid, in_ready, mul_start);
      end
    end
    mul_done = 1'b0;
    run_op(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 3, 2, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a, b;
      logic        s;
      int          d, r;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
      s = 1'($urandom);
      d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      r = int'($urandom_range(0, 3));
      run_op(a, b, s, d, r, $sformatf("rand%0d", n));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_timeout();
    test_hold_backpressure();
    test_idle_done_ignored();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
